line_decoder_seq: RTL and testbench
===================================

# line_decoder_seq

Parametrised, registered N-to-2^N line decoder with a valid/ready input handshake and timed one-hot output strobes. It is the successor of our fixed 2-to-4 combinational decoder. It drives one-hot select lines, such as display digits, keypad rows or bank enables, that must each be held for a programmed number of cycles followed by a blanking gap. It sits between a code producer (controller or scan logic) and the physical select lines.

## Interface
Parameters:
- SEL_W, 2: select code width; output width is OUT_W = 2^SEL_W (legal range 1..6).
- HOLD, 4: cycles each decoded line stays active (≥1).
- GAP, 1: blanking cycles with all lines inactive after each hold (≥0).
- ACTIVE_LOW, 0: 1 inverts every bit of `D` (active line = 0, inactive = 1).

Ports (clock and reset first):
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; 0 freezes the sequencer and blanks `D`.
- sel_valid  input  1  producer presents a code on `A`.
- A  input  SEL_W  select code.
- sel_ready  output  1  block accepts a code this cycle.
- D  output  OUT_W  one-hot decoded lines (polarity per ACTIVE_LOW).
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse on the last cycle of a strobe sequence.
- cur_sel  output  SEL_W  last accepted code.

## Operation
- FSM states: IDLE, HOLD_S, GAP_S. A down-counter of width clog2(max(HOLD,GAP)+1) times each state.
- IDLE: `sel_ready = en`. A handshake (`sel_valid & sel_ready`) latches `A` into `cur_sel`, loads the counter with HOLD, and moves to HOLD_S.
- HOLD_S: `D[cur_sel]` is active and all other bits are inactive. When the counter expires:
  - GAP > 0: go to GAP_S.
  - GAP = 0: go to IDLE.
- GAP_S: all bits of `D` are inactive. When the counter expires, go to IDLE.
- `done` is a registered pulse, high for the final cycle of HOLD_S (if GAP = 0) or of GAP_S.
- `sel_ready` is 0 outside IDLE. There is no queueing, and `A`/`sel_valid` are ignored while busy.
- `en = 0`, any state: counter and state hold, `D` is forced inactive, and `sel_ready = 0`. When `en` returns, the sequence resumes with the remaining count. Frozen cycles do not count toward HOLD or GAP.
- Every code is valid (full decode), so there is no error output.
- Reset (also mid-sequence): state goes to IDLE, the counter clears, `D` becomes all-inactive (0s, or 1s when ACTIVE_LOW = 1), and `busy = 0`, `done = 0`, `cur_sel = 0`. After reset, `sel_ready = en`.

## Timing
- Handshake at edge k: `D` is active during cycles k+1 … k+HOLD, and blank during k+HOLD+1 … k+HOLD+GAP.
- `done` is high in cycle k+HOLD+GAP.
- `sel_ready` is high again in cycle k+HOLD+GAP+1, provided `en = 1`.
- Throughput: one code per HOLD+GAP+1 cycles, with no frozen cycles.
- All outputs are registered, so there are no combinational paths from inputs to outputs. Exception: `sel_ready`, which is decoded from state and `en`.

## Configuration
- `LINE_DECODER_AUTOSCAN_EN` defined:
  - Adds an input port `scan_en` (1 bit).
  - In IDLE with `en = 1`, `scan_en = 1` and `sel_valid = 0`, the block self-starts with code `(cur_sel + 1) mod OUT_W`, wrapping from OUT_W-1 to 0.
  - An external handshake has priority over autoscan in the same cycle.
  - A scan-internal "last code" register resets to OUT_W-1, so the first scanned code is 0.
- `LINE_DECODER_AUTOSCAN_EN` undefined: the `scan_en` port is absent, and sequences start only via the handshake.

## Test plan
- Reset, defaults: `D = 4'b0000`, `busy = 0`, `done = 0`, `cur_sel = 0`; `sel_ready = 1` with `en = 1`.
- `A = 2`, handshake at edge 0:
  - `D = 4'b0100` in cycles 1–4.
  - `D = 4'b0000` with `done = 1` in cycle 5.
  - `sel_ready = 1` in cycle 6.
- `A = 1` accepted, then `en = 0` for 3 cycles in the middle of HOLD: `D = 0` and the count is frozen. After `en` returns, `D = 4'b0010` for exactly the remaining HOLD cycles, and `done` is delayed by 3 cycles.
- Assert `rst` in cycle 2 of HOLD: `D = 0`, `busy = 0` immediately (asynchronous). After release, a new code `A = 3` yields `D = 4'b1000` per the normal timing.
- SEL_W = 3, ACTIVE_LOW = 1, GAP = 0, `A = 7`: `D = 8'b0111_1111` for HOLD cycles, with `done` on the last of them. `D = 8'hFF` at all other times.
- `LINE_DECODER_AUTOSCAN_EN` defined, `scan_en = 1`, no `sel_valid`: codes 0, 1, 2, 3, 0 are strobed in order, each separated by HOLD+GAP+1 cycles. A `sel_valid` with `A = 2` arriving in IDLE overrides the next scan code.

Source files
------------

// File: rtl/line_decoder_seq.sv
// Purpose : registered N-to-2^N line decoder that strobes one select line for HOLD
//           cycles, then blanks all lines for GAP cycles, then returns to idle.
// Latency : D goes active one cycle after the accepting edge. sel_ready rises again
//           HOLD+GAP+1 cycles after the accepting edge.
// Backpr. : sel_ready is high only in IDLE with en=1, and nothing is queued.
//           en=0 freezes the sequence in place and blanks D.
//
// Optional feature macro: LINE_DECODER_AUTOSCAN_EN
//   When it is defined, a scan_en input is added. While scan_en is set and the block
//   is idle and enabled, it starts itself with the code after the last code it
//   strobed, wrapping from OUT_W-1 to 0. An external handshake wins in the same cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         global enable; 0 freezes the sequencer and blanks D
//   sel_valid  producer presents a code on A
//   A          select code (SEL_W bits); every value is a legal code
//   scan_en    (LINE_DECODER_AUTOSCAN_EN only) enables self-starting scan
//   sel_ready  accept strobe (the only output decoded combinationally from state/en)
//   D          one-hot select lines (polarity set by ACTIVE_LOW)
//   busy       high while in HOLD or GAP
//   done       one-cycle pulse on the last cycle of a strobe sequence
//   cur_sel    last accepted code
module line_decoder_seq #(
    parameter int SEL_W      = 2,    // legal range 1..6
    parameter int HOLD       = 4,    // >= 1
    parameter int GAP        = 1,    // >= 0
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        A,
`ifdef LINE_DECODER_AUTOSCAN_EN
    input  logic                    scan_en,
`endif
    output logic                    sel_ready,
    output logic [(1<<SEL_W)-1:0]   D,
    output logic                    busy,
    output logic                    done,
    output logic [SEL_W-1:0]        cur_sel
);

    localparam int OUT_W   = 1 << SEL_W;
    localparam int MAX_CNT = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam bit HAS_GAP = (GAP > 0);

    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Value of D with every line inactive. XOR-ing a one-hot vector with this
    // applies the output polarity in one step.
    localparam logic [OUT_W-1:0] D_IDLE = {OUT_W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_S = 2'd1,
        GAP_S  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [OUT_W-1:0]   d_q,     d_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               handshake;
    logic               start;
    logic [SEL_W-1:0]   start_code;
    logic [OUT_W-1:0]   decoded;
    logic               last_cycle_d;

    // The ready strobe is the only output that follows en within the same cycle.
    assign sel_ready = en & (state_q == IDLE);
    assign handshake = sel_valid & sel_ready;

`ifdef LINE_DECODER_AUTOSCAN_EN
    // Code most recently started by either source. It resets to OUT_W-1 so that
    // the first scanned code is 0. cur_sel resets to 0, so cur_sel cannot serve here.
    logic [SEL_W-1:0]   scan_last_q, scan_last_d;
    logic [SEL_W-1:0]   scan_code;
    logic               scan_go;

    // The adder width equals SEL_W, so the wrap from OUT_W-1 to 0 is free.
    assign scan_code  = scan_last_q + SEL_W'(1);
    assign scan_go    = (state_q == IDLE) & en & scan_en & ~sel_valid;
    assign start      = handshake | scan_go;
    assign start_code = handshake ? A : scan_code;
    assign scan_last_d = start ? start_code : scan_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_last_q <= {SEL_W{1'b1}};
        end else begin
            scan_last_q <= scan_last_d;
        end
    end
`else
    assign start      = handshake;
    assign start_code = A;
`endif

    // Next-state logic. Every transition is gated by en, so a frozen cycle
    // leaves both the state and the remaining count untouched.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = HOLD_S;
                        cnt_d     = CNT_HOLD;
                        cur_sel_d = start_code;
                    end
                end
                HOLD_S: begin
                    // <= instead of == so that a stray zero count cannot wrap.
                    if (cnt_q <= CNT_ONE) begin
                        if (HAS_GAP) begin
                            state_d = GAP_S;
                            cnt_d   = CNT_GAP;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                GAP_S: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered outputs are computed from the next state. Each output then shows
    // the state during the cycle it describes, with no extra lag.
    always_comb begin
        decoded = '0;
        if (en && (state_d == HOLD_S)) begin
            decoded[cur_sel_d] = 1'b1;
        end
        d_d    = decoded ^ D_IDLE;
        busy_d = (state_d != IDLE);

        // The sequence ends on the last GAP cycle. Without a gap it ends on the
        // last HOLD cycle. While en=0 the count cannot move, so this is true for
        // only one enabled edge.
        last_cycle_d = 1'b0;
        if (cnt_d == CNT_ONE) begin
            if (state_d == GAP_S) begin
                last_cycle_d = 1'b1;
            end else if (!HAS_GAP && (state_d == HOLD_S)) begin
                last_cycle_d = 1'b1;
            end
        end
        done_d = en & last_cycle_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            d_q       <= D_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            d_q       <= d_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign D       = d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_line_decoder_seq.sv
module tb_line_decoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;

    // Default instance: SEL_W=2, HOLD=4, GAP=1, active-high
    logic       sel_valid;
    logic [1:0] A;
    logic       sel_ready;
    logic [3:0] D;
    logic       busy;
    logic       done;
    logic [1:0] cur_sel;
    logic       scan_en;

    // Second instance: SEL_W=3, HOLD=4, GAP=0, active-low
    logic       sel_valid2;
    logic [2:0] A2;
    logic       sel_ready2;
    logic [7:0] D2;
    logic       busy2;
    logic       done2;
    logic [2:0] cur_sel2;
    logic       scan_en2;

    int checks = 0;
    int errors = 0;
    int test_id = 0;
    int cyc = 0;

    typedef struct {
        int         which;
        logic [7:0] d;
        logic       dn;
        logic       bz;
        logic       rdy;
        logic [7:0] cur;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    line_decoder_seq #(.SEL_W(2), .HOLD(4), .GAP(1), .ACTIVE_LOW(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel_valid (sel_valid),
        .A         (A),
`ifdef LINE_DECODER_AUTOSCAN_EN
        .scan_en   (scan_en),
`endif
        .sel_ready (sel_ready),
        .D         (D),
        .busy      (busy),
        .done      (done),
        .cur_sel   (cur_sel)
    );

    line_decoder_seq #(.SEL_W(3), .HOLD(4), .GAP(0), .ACTIVE_LOW(1'b1)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel_valid (sel_valid2),
        .A         (A2),
`ifdef LINE_DECODER_AUTOSCAN_EN
        .scan_en   (scan_en2),
`endif
        .sel_ready (sel_ready2),
        .D         (D2),
        .busy      (busy2),
        .done      (done2),
        .cur_sel   (cur_sel2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int which, input logic [7:0] d, input logic dn,
                        input logic bz, input logic rdy, input logic [7:0] cur);
        exp_t e;
        e.which = which;
        e.d     = d;
        e.dn    = dn;
        e.bz    = bz;
        e.rdy   = rdy;
        e.cur   = cur;
        q.push_back(e);
    endtask

    // Expected per-cycle trace of one strobe sequence that starts at the next edge:
    // HOLD active cycles, then GAP blank cycles, then one idle cycle.
    task automatic push_strobe(input int which, input logic [7:0] code, input int hold,
                               input int gap, input logic al, input int outw);
        logic [8:0] m;
        logic [7:0] inact;
        logic [7:0] act;
        m     = (9'd1 << outw) - 9'd1;
        inact = al ? m[7:0] : 8'h00;
        act   = (8'd1 << code) ^ inact;
        for (int i = 0; i < hold; i++)
            push(which, act, (gap == 0) && (i == hold - 1), 1'b1, 1'b0, code);
        for (int i = 0; i < gap; i++)
            push(which, inact, (i == gap - 1), 1'b1, 1'b0, code);
        push(which, inact, 1'b0, 1'b0, 1'b1, code);
    endtask

    // Advance one clock. Sample 1 time unit after the edge, then score the oldest
    // expectation, if one is pending.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.which == 1) begin
                chk($sformatf("t%0d_c%0d_D", test_id, cyc),    {4'b0, D},       e.d);
                chk($sformatf("t%0d_c%0d_done", test_id, cyc), {7'b0, done},    {7'b0, e.dn});
                chk($sformatf("t%0d_c%0d_busy", test_id, cyc), {7'b0, busy},    {7'b0, e.bz});
                chk($sformatf("t%0d_c%0d_rdy", test_id, cyc),  {7'b0, sel_ready}, {7'b0, e.rdy});
                chk($sformatf("t%0d_c%0d_cur", test_id, cyc),  {6'b0, cur_sel}, e.cur);
            end else begin
                chk($sformatf("t%0d_c%0d_D2", test_id, cyc),    D2,               e.d);
                chk($sformatf("t%0d_c%0d_done2", test_id, cyc), {7'b0, done2},    {7'b0, e.dn});
                chk($sformatf("t%0d_c%0d_busy2", test_id, cyc), {7'b0, busy2},    {7'b0, e.bz});
                chk($sformatf("t%0d_c%0d_rdy2", test_id, cyc),  {7'b0, sel_ready2}, {7'b0, e.rdy});
                chk($sformatf("t%0d_c%0d_cur2", test_id, cyc),  {5'b0, cur_sel2}, e.cur);
            end
        end
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        sel_valid  = 1'b0;
        A          = 2'd0;
        sel_valid2 = 1'b0;
        A2         = 3'd0;
        scan_en    = 1'b0;
        scan_en2   = 1'b0;

        // Reset defaults
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_D",     {4'b0, D},        8'h00);
        chk("rst_busy",  {7'b0, busy},     8'h00);
        chk("rst_done",  {7'b0, done},     8'h00);
        chk("rst_cur",   {6'b0, cur_sel},  8'h00);
        chk("rst_rdy",   {7'b0, sel_ready}, 8'h01);
        chk("rst_D2",    D2,               8'hFF);
        chk("rst_rdy2",  {7'b0, sel_ready2}, 8'h01);
        en = 1'b0;
        #1;
        chk("idle_rdy_en0", {7'b0, sel_ready}, 8'h00);
        en = 1'b1;
        #1;

        // Test 1: A=2, normal timing
        test_id = 1; cyc = 0;
        A = 2'd2; sel_valid = 1'b1;
        chk("t1_rdy_pre", {7'b0, sel_ready}, 8'h01);
        push_strobe(1, 8'd2, 4, 1, 1'b0, 4);
        step();
        sel_valid = 1'b0; A = 2'd0;
        drain();

        // Test 2: A=1 with three frozen cycles in the middle of HOLD
        test_id = 2; cyc = 0;
        A = 2'd1; sel_valid = 1'b1;
        push(1, 8'h02, 1'b0, 1'b1, 1'b0, 8'd1);
        push(1, 8'h02, 1'b0, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 3; i++) push(1, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1);
        push(1, 8'h02, 1'b0, 1'b1, 1'b0, 8'd1);
        push(1, 8'h02, 1'b0, 1'b1, 1'b0, 8'd1);
        push(1, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1);
        push(1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1);
        step();
        sel_valid = 1'b0;
        step();
        en = 1'b0;
        step(); step(); step();
        en = 1'b1;
        drain();

        // Test 3: asynchronous reset in cycle 2 of HOLD, then A=3
        test_id = 3; cyc = 0;
        A = 2'd0; sel_valid = 1'b1;
        push(1, 8'h01, 1'b0, 1'b1, 1'b0, 8'd0);
        push(1, 8'h01, 1'b0, 1'b1, 1'b0, 8'd0);
        step();
        sel_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t3_rst_D",    {4'b0, D},       8'h00);
        chk("t3_rst_busy", {7'b0, busy},    8'h00);
        chk("t3_rst_done", {7'b0, done},    8'h00);
        chk("t3_rst_cur",  {6'b0, cur_sel}, 8'h00);
        #1;
        rst = 1'b0;
        #1;
        chk("t3_rdy_after_rst", {7'b0, sel_ready}, 8'h01);
        test_id = 4; cyc = 0;
        A = 2'd3; sel_valid = 1'b1;
        push_strobe(1, 8'd3, 4, 1, 1'b0, 4);
        step();
        sel_valid = 1'b0;
        drain();

        // Test 5: SEL_W=3, active-low, GAP=0, A=7
        test_id = 5; cyc = 0;
        A2 = 3'd7; sel_valid2 = 1'b1;
        push_strobe(2, 8'd7, 4, 0, 1'b1, 8);
        step();
        sel_valid2 = 1'b0;
        drain();

`ifdef LINE_DECODER_AUTOSCAN_EN
        // Test 6: autoscan 0,1,2,3,0, then an external A=2 overrides the next scan code
        test_id = 6; cyc = 0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        scan_en = 1'b1;
        push_strobe(1, 8'd0, 4, 1, 1'b0, 4); drain();
        push_strobe(1, 8'd1, 4, 1, 1'b0, 4); drain();
        push_strobe(1, 8'd2, 4, 1, 1'b0, 4); drain();
        push_strobe(1, 8'd3, 4, 1, 1'b0, 4); drain();
        push_strobe(1, 8'd0, 4, 1, 1'b0, 4); drain();
        A = 2'd2; sel_valid = 1'b1;
        push_strobe(1, 8'd2, 4, 1, 1'b0, 4);
        step();
        sel_valid = 1'b0;
        drain();
        push_strobe(1, 8'd3, 4, 1, 1'b0, 4); drain();
        scan_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
